// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
package mem_arb_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 8;

    localparam int P0 = 0;
    localparam int P1 = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic                      wr_rd;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0]      wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_rr_arbiter_pick.sv
// Combinational two-way round-robin picker; last_grant_i is the index of the previous winner.
module mem_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port memory, with a ready watchdog.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_valid_i,
    input  logic                  p0_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [WIDTH-1:0]      p0_wdata_i,
    output logic                  p0_ready_o,
    output logic [WIDTH-1:0]      p0_rdata_o,
    output logic                  p0_rsp_valid_o,
    output logic                  p0_rsp_err_o,

    input  logic                  p1_valid_i,
    input  logic                  p1_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [WIDTH-1:0]      p1_wdata_i,
    output logic                  p1_ready_o,
    output logic [WIDTH-1:0]      p1_rdata_o,
    output logic                  p1_rsp_valid_o,
    output logic                  p1_rsp_err_o,

    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic                  mem_ready_i,

    output logic                  busy_o,
    output logic [1:0]            grant_o
);

    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_e                state_q;
    logic                  last_q;
    logic [1:0]            grant_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic [WD_W-1:0]       wd_q;
    logic [1:0]            rsp_valid_q;
    logic [1:0]            rsp_err_q;
    logic [WIDTH-1:0]      p0_rdata_q;
    logic [WIDTH-1:0]      p1_rdata_q;

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  idle;
    logic                  wd_expire;
    logic                  xfer_ok;
    logic                  xfer_to;
    logic                  done;
    logic                  sel_wr_rd;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [WIDTH-1:0]      rsp_rdata_d;

    assign req = {p1_valid_i, p0_valid_i};

    mem_rr_pick u_pick (
        .req_i        (req),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    assign idle       = (state_q == ST_IDLE);
    assign p0_ready_o = idle & gnt[P0];
    assign p1_ready_o = idle & gnt[P1];

    assign sel_wr_rd = gnt[P1] ? p1_wr_rd_i : p0_wr_rd_i;
    assign sel_addr  = gnt[P1] ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = gnt[P1] ? p1_wdata_i : p0_wdata_i;

    // A ready on the expiry cycle wins over the watchdog.
    assign wd_expire   = (TIMEOUT > 0) && (wd_q == WD_LAST[WD_W-1:0]);
    assign xfer_ok     = !idle && mem_ready_i;
    assign xfer_to     = !idle && !mem_ready_i && wd_expire;
    assign done        = xfer_ok || xfer_to;
    assign rsp_rdata_d = (xfer_ok && !mem_wr_rd_q) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            grant_q     <= '0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wd_q        <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            if (state_q == ST_IDLE) begin
                if (|req) begin
                    state_q     <= ST_BUSY;
                    grant_q     <= gnt;
                    last_q      <= gnt[P1];
                    mem_wr_rd_q <= sel_wr_rd;
                    mem_addr_q  <= sel_addr;
                    mem_wdata_q <= sel_wdata;
                    wd_q        <= '0;
                end
            end else if (done) begin
                state_q     <= ST_IDLE;
                grant_q     <= '0;
                mem_wr_rd_q <= 1'b0;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                rsp_valid_q <= grant_q;
                if (grant_q[P0]) begin
                    p0_rdata_q    <= rsp_rdata_d;
                    rsp_err_q[P0] <= xfer_to;
                end
                if (grant_q[P1]) begin
                    p1_rdata_q    <= rsp_rdata_d;
                    rsp_err_q[P1] <= xfer_to;
                end
            end else begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    assign busy_o         = (state_q == ST_BUSY);
    assign grant_o        = grant_q;
    assign mem_valid_o    = (state_q == ST_BUSY);
    assign mem_wr_rd_o    = mem_wr_rd_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign p0_rsp_valid_o = rsp_valid_q[P0];
    assign p1_rsp_valid_o = rsp_valid_q[P1];
    assign p0_rsp_err_o   = rsp_err_q[P0];
    assign p1_rsp_err_o   = rsp_err_q[P1];
    assign p0_rdata_o     = p0_rdata_q;
    assign p1_rdata_o     = p1_rdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: vector table, directed corner sequences, random traffic vs a transaction model.
module tb_mem_rr_arbiter;
    import mem_arb_pkg::*;

    localparam int W  = 16;
    localparam int AW = 8;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          p0_valid_i, p0_wr_rd_i, p0_ready_o, p0_rsp_valid_o, p0_rsp_err_o;
    logic [AW-1:0] p0_addr_i;
    logic [W-1:0]  p0_wdata_i, p0_rdata_o;
    logic          p1_valid_i, p1_wr_rd_i, p1_ready_o, p1_rsp_valid_o, p1_rsp_err_o;
    logic [AW-1:0] p1_addr_i;
    logic [W-1:0]  p1_wdata_i, p1_rdata_o;
    logic          mem_valid_o, mem_wr_rd_o, mem_ready_i, busy_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_wdata_o, mem_rdata_i;
    logic [1:0]    grant_o;

    mem_rr_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .p0_valid_i     (p0_valid_i),
        .p0_wr_rd_i     (p0_wr_rd_i),
        .p0_addr_i      (p0_addr_i),
        .p0_wdata_i     (p0_wdata_i),
        .p0_ready_o     (p0_ready_o),
        .p0_rdata_o     (p0_rdata_o),
        .p0_rsp_valid_o (p0_rsp_valid_o),
        .p0_rsp_err_o   (p0_rsp_err_o),
        .p1_valid_i     (p1_valid_i),
        .p1_wr_rd_i     (p1_wr_rd_i),
        .p1_addr_i      (p1_addr_i),
        .p1_wdata_i     (p1_wdata_i),
        .p1_ready_o     (p1_ready_o),
        .p1_rdata_o     (p1_rdata_o),
        .p1_rsp_valid_o (p1_rsp_valid_o),
        .p1_rsp_err_o   (p1_rsp_err_o),
        .mem_valid_o    (mem_valid_o),
        .mem_wr_rd_o    (mem_wr_rd_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ready_i    (mem_ready_i),
        .busy_o         (busy_o),
        .grant_o        (grant_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int p0_v, p0_wr, p0_addr, p0_wd;
        int p1_v, p1_wr, p1_addr, p1_wd;
        int m_rdy, m_rd;
        int e_rdy, e_mv, e_mwr, e_maddr, e_mwd, e_gnt, e_rsp, e_rd0, e_rd1, e_err;
    } vec_t;

    typedef struct {
        int           port;
        int           due;
        logic [W-1:0] rdata;
        logic         err;
    } rsp_t;

    vec_t         vec[9];
    rsp_t         exp_q[$];
    logic [W-1:0] mem_arr[256];
    logic [W-1:0] ref_mem[256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        p0_valid_i = 0; p0_wr_rd_i = 0; p0_addr_i = '0; p0_wdata_i = '0;
        p1_valid_i = 0; p1_wr_rd_i = 0; p1_addr_i = '0; p1_wdata_i = '0;
        mem_ready_i = 0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 0;
        repeat (2) tick();
        rst_i = 1;
        tick();
    endtask

    // p0 read with memory ready on busy cycle rdy_at (0 = never).
    task automatic run_wd(input int rdy_at, input logic [W-1:0] d, input logic e_err, input logic [W-1:0] e_rd);
        int nb;
        p0_valid_i = 1; p0_wr_rd_i = 0; p0_addr_i = 8'h20;
        settle();
        chk("wd_accept", 32'(p0_ready_o), 1);
        tick();
        p0_valid_i = 0;
        mem_rdata_i = d;
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            if (!busy_o) break;
            nb++;
            mem_ready_i = (nb == rdy_at);
            settle();
            chk("wd_addr_hold", 32'(mem_addr_o), 32'h20);
            tick();
        end
        mem_ready_i = 0;
        settle();
        chk("wd_busy_cycles", 32'(nb), 32'(TO));
        chk("wd_mem_valid", 32'(mem_valid_o), 0);
        chk("wd_rsp_valid", 32'(p0_rsp_valid_o), 1);
        chk("wd_rsp_err", 32'(p0_rsp_err_o), 32'(e_err));
        chk("wd_rdata", 32'(p0_rdata_o), 32'(e_rd));
        tick();
    endtask

    initial begin
        int n0, n1;
        int order[$];
        int gcyc[$];
        int exp_addr;

        vec[0] = '{1, 1, 'h10, 'hBEEF, 0, 0, 0, 0, 0, 0,      'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vec[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0,              'b00, 1, 1, 'h10, 'hBEEF, 'b01, 0, 0, 0, 0};
        vec[2] = '{0, 0, 0, 0, 1, 0, 'h10, 0, 0, 0,           'b10, 0, 0, 0, 0, 0, 'b01, 0, 0, 0};
        vec[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5555,         'b00, 1, 0, 'h10, 0, 'b10, 0, 0, 0, 0};
        vec[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'hAAAA,         'b00, 1, 0, 'h10, 0, 'b10, 0, 0, 0, 0};
        vec[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1111,         'b00, 1, 0, 'h10, 0, 'b10, 0, 0, 0, 0};
        vec[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 'hBEEF,         'b00, 1, 0, 'h10, 0, 'b10, 0, 0, 0, 0};
        vec[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              'b00, 0, 0, 0, 0, 0, 'b10, 0, 'hBEEF, 0};
        vec[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              'b00, 0, 0, 0, 0, 0, 0, 0, 'hBEEF, 0};

        // Reset values while reset is held.
        clear_inputs();
        rst_i = 0;
        repeat (2) tick();
        settle();
        chk("rst_mem_valid", 32'(mem_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_mem_addr", 32'(mem_addr_o), 0);
        chk("rst_mem_wdata", 32'(mem_wdata_o), 0);
        chk("rst_mem_wr", 32'(mem_wr_rd_o), 0);
        chk("rst_rsp", 32'({p1_rsp_valid_o, p0_rsp_valid_o}), 0);
        chk("rst_err", 32'({p1_rsp_err_o, p0_rsp_err_o}), 0);
        chk("rst_rdata0", 32'(p0_rdata_o), 0);
        chk("rst_rdata1", 32'(p1_rdata_o), 0);
        rst_i = 1;
        tick();

        // Write then wait-stated read, one row per cycle.
        for (int i = 0; i < 9; i++) begin
            p0_valid_i = 1'(vec[i].p0_v); p0_wr_rd_i = 1'(vec[i].p0_wr);
            p0_addr_i = 8'(vec[i].p0_addr); p0_wdata_i = 16'(vec[i].p0_wd);
            p1_valid_i = 1'(vec[i].p1_v); p1_wr_rd_i = 1'(vec[i].p1_wr);
            p1_addr_i = 8'(vec[i].p1_addr); p1_wdata_i = 16'(vec[i].p1_wd);
            mem_ready_i = 1'(vec[i].m_rdy); mem_rdata_i = 16'(vec[i].m_rd);
            settle();
            chk($sformatf("v%0d_ready", i), 32'({p1_ready_o, p0_ready_o}), 32'(vec[i].e_rdy));
            chk($sformatf("v%0d_mem_valid", i), 32'(mem_valid_o), 32'(vec[i].e_mv));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vec[i].e_mv));
            chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr_rd_o), 32'(vec[i].e_mwr));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr_o), 32'(vec[i].e_maddr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata_o), 32'(vec[i].e_mwd));
            chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vec[i].e_gnt));
            chk($sformatf("v%0d_rsp", i), 32'({p1_rsp_valid_o, p0_rsp_valid_o}), 32'(vec[i].e_rsp));
            chk($sformatf("v%0d_rdata0", i), 32'(p0_rdata_o), 32'(vec[i].e_rd0));
            chk($sformatf("v%0d_rdata1", i), 32'(p1_rdata_o), 32'(vec[i].e_rd1));
            chk($sformatf("v%0d_err", i), 32'({p1_rsp_err_o, p0_rsp_err_o}), 32'(vec[i].e_err));
            tick();
        end

        // Fairness: both ports stream three writes each against an always-ready memory.
        do_reset();
        n0 = 0; n1 = 0; exp_addr = 0;
        for (int k = 0; k < 16; k++) begin
            mem_ready_i = mem_valid_o;
            p0_valid_i = (n0 < 3); p0_wr_rd_i = 1; p0_addr_i = 8'(2 * n0);     p0_wdata_i = 16'(100 + n0);
            p1_valid_i = (n1 < 3); p1_wr_rd_i = 1; p1_addr_i = 8'(2 * n1 + 1); p1_wdata_i = 16'(200 + n1);
            settle();
            if (mem_valid_o) chk("fair_mem_addr", 32'(mem_addr_o), 32'(exp_addr));
            if (p0_ready_o) begin order.push_back(0); gcyc.push_back(cyc); exp_addr = int'(p0_addr_i); n0++; end
            if (p1_ready_o) begin order.push_back(1); gcyc.push_back(cyc); exp_addr = int'(p1_addr_i); n1++; end
            tick();
        end
        clear_inputs();
        chk("fair_p0_pulses", 32'(n0), 3);
        chk("fair_p1_pulses", 32'(n1), 3);
        chk("fair_grants", 32'(order.size()), 6);
        for (int i = 0; i < order.size(); i++) begin
            chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 2);
        end

        // Watchdog: ready on the last allowed cycle succeeds, no ready at all times out.
        do_reset();
        run_wd(TO, 16'h1234, 1'b0, 16'h1234);
        run_wd(0, 16'h5678, 1'b1, 16'h0000);

        // Asynchronous reset in the middle of a wait-stated read.
        do_reset();
        p1_valid_i = 1; p1_wr_rd_i = 0; p1_addr_i = 8'h30;
        settle();
        chk("mrst_accept", 32'(p1_ready_o), 1);
        tick();
        p1_valid_i = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("mrst_busy_before", 32'(busy_o), 1);
            tick();
        end
        #2;
        rst_i = 0;
        #1;
        chk("mrst_mem_valid", 32'(mem_valid_o), 0);
        chk("mrst_busy", 32'(busy_o), 0);
        chk("mrst_grant", 32'(grant_o), 0);
        chk("mrst_rsp", 32'(p1_rsp_valid_o), 0);
        tick();
        chk("mrst_rsp_hold", 32'(p1_rsp_valid_o), 0);
        rst_i = 1;
        tick();
        chk("mrst_rsp_after", 32'({p1_rsp_valid_o, p0_rsp_valid_o}), 0);

        // Memory ready while idle is ignored.
        for (int k = 0; k < 3; k++) begin
            mem_ready_i = 1; mem_rdata_i = 16'hDEAD;
            settle();
            chk("idle_rdy_rsp", 32'({p1_rsp_valid_o, p0_rsp_valid_o}), 0);
            chk("idle_rdy_busy", 32'(busy_o), 0);
            chk("idle_rdy_mem", 32'({mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o}), 0);
            chk("idle_rdy_grant", 32'(grant_o), 0);
            tick();
        end
        mem_ready_i = 0;

        // After reset port 0 wins the first tie.
        p0_valid_i = 1; p1_valid_i = 1;
        settle();
        chk("tie_p0_ready", 32'(p0_ready_o), 1);
        chk("tie_p1_ready", 32'(p1_ready_o), 0);
        tick();
        clear_inputs();
        settle();
        chk("tie_grant", 32'(grant_o), 32'b01);

        // Random traffic against a transaction-level model.
        do_reset();
        begin
            int       last_w, free_cyc, busy_cnt, cur_lat, win;
            bit       pv[2];
            bit       ev, av;
            mem_req_t preq[2];
            mem_req_t cur;
            rsp_t     e;
            logic [W-1:0] ardata;
            logic         aerr;

            for (int a = 0; a < 256; a++) begin
                mem_arr[a] = '0;
                ref_mem[a] = '0;
            end
            last_w = 1; free_cyc = 0; busy_cnt = 0; cur_lat = 0;
            pv[0] = 0; pv[1] = 0;
            cur = '0; preq[0] = '0; preq[1] = '0;

            for (int k = 0; k < 700; k++) begin
                for (int p = 0; p < 2; p++) begin
                    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc) && (exp_q[0].port == p);
                    av = (p == 0) ? p0_rsp_valid_o : p1_rsp_valid_o;
                    ardata = (p == 0) ? p0_rdata_o : p1_rdata_o;
                    aerr = (p == 0) ? p0_rsp_err_o : p1_rsp_err_o;
                    chk($sformatf("rnd_rsp_valid%0d", p), 32'(av), 32'(ev));
                    if (ev && av) begin
                        chk($sformatf("rnd_rdata%0d", p), 32'(ardata), 32'(exp_q[0].rdata));
                        chk($sformatf("rnd_err%0d", p), 32'(aerr), 32'(exp_q[0].err));
                    end
                end
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());

                chk("rnd_busy", 32'(busy_o), 32'(cyc < free_cyc));
                if (mem_valid_o) begin
                    chk("rnd_mem_req", 32'({mem_wr_rd_o, mem_addr_o, mem_wdata_o}), 32'(cur));
                    mem_ready_i = (busy_cnt == cur_lat);
                    mem_rdata_i = mem_arr[mem_addr_o];
                    if (mem_ready_i && mem_wr_rd_o) mem_arr[mem_addr_o] = mem_wdata_o;
                    busy_cnt++;
                end else begin
                    busy_cnt = 0;
                    mem_ready_i = ($urandom_range(0, 3) == 0);
                    mem_rdata_i = 16'($urandom);
                end

                for (int p = 0; p < 2; p++) begin
                    if (!pv[p] && k < 600 && $urandom_range(0, 2) != 0) begin
                        pv[p] = 1;
                        preq[p].wr_rd = 1'($urandom_range(0, 1));
                        preq[p].addr  = 8'($urandom_range(0, 15));
                        preq[p].wdata = 16'($urandom);
                    end
                end
                p0_valid_i = pv[0]; p0_wr_rd_i = preq[0].wr_rd; p0_addr_i = preq[0].addr; p0_wdata_i = preq[0].wdata;
                p1_valid_i = pv[1]; p1_wr_rd_i = preq[1].wr_rd; p1_addr_i = preq[1].addr; p1_wdata_i = preq[1].wdata;
                settle();

                win = -1;
                if (cyc >= free_cyc) begin
                    if (pv[0] && pv[1]) win = 1 - last_w;
                    else if (pv[0]) win = 0;
                    else if (pv[1]) win = 1;
                end
                chk("rnd_p0_ready", 32'(p0_ready_o), 32'(win == 0));
                chk("rnd_p1_ready", 32'(p1_ready_o), 32'(win == 1));
                if (win >= 0) begin
                    last_w = win;
                    cur = preq[win];
                    pv[win] = 0;
                    cur_lat = $urandom_range(0, 10);
                    e.port = win;
                    if (cur_lat < TO) begin
                        e.due = cyc + 2 + cur_lat;
                        e.err = 1'b0;
                        e.rdata = cur.wr_rd ? '0 : ref_mem[cur.addr];
                        if (cur.wr_rd) ref_mem[cur.addr] = cur.wdata;
                    end else begin
                        e.due = cyc + 1 + TO;
                        e.err = 1'b1;
                        e.rdata = '0;
                    end
                    free_cyc = e.due;
                    exp_q.push_back(e);
                end
                tick();
            end
            chk("rnd_drain", 32'(exp_q.size()), 0);
            chk("rnd_pending", 32'({pv[1], pv[0]}), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
